reaction_controller: RTL and testbench

REACTION_CONTROLLER -- requirements
Module: reaction_controller

---
 rtl/reaction_pkg.sv | 18 +
 rtl/rt_lfsr16.sv | 29 ++
 rtl/reaction_controller.sv | 120 ++++++++++++
 tb/tb_reaction_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time controller: FSM state encodings
// and the LFSR seed/tap constants.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_REACT   = 3'd2,
        ST_RESULT  = 3'd3,
        ST_EARLY   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/rt_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR supplying the random part of the wait.
// Starting from a non-zero seed, the maximal-length sequence never reaches zero.
module rt_lfsr16
    import reaction_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game controller: random wait, stimulus lamp, reaction window,
// and control of an external ms counter that measures the response.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 11,
    parameter int TIMEOUT_MS  = 9999
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Tick_ms,
    output logic       Counter_clear,
    output logic       Counter_enable,
    output logic       Led,
    output logic       Result_valid,
    output logic       Early,
    output logic       Timeout,
    output logic [2:0] State
);

    localparam int WAIT_MAX = MIN_WAIT_MS + (1 << RAND_BITS) - 1;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int REACT_W  = $clog2(TIMEOUT_MS + 1);

    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]  WAIT_MIN   = WAIT_W'(MIN_WAIT_MS);
    localparam logic [REACT_W-1:0] REACT_LAST = REACT_W'(TIMEOUT_MS - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [REACT_W-1:0]  react_cnt_q, react_cnt_d;
    logic                start_q, stop_q;
    logic                clear_q, clear_d;
    logic [15:0]         lfsr;
    logic                start_edge, stop_edge;
    logic [WAIT_W-1:0]   wait_load;

    rt_lfsr16 u_lfsr (
        .Clock  (Clock),
        .Resetn (Resetn),
        .q      (lfsr)
    );

    assign start_edge = Start & ~start_q;
    assign stop_edge  = Stop & ~stop_q;
    assign wait_load  = WAIT_MIN + WAIT_W'(lfsr[RAND_BITS-1:0]);

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        react_cnt_d = react_cnt_q;
        clear_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESULT, ST_EARLY, ST_TIMEOUT: begin
                if (start_edge) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_load;
                    clear_d    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (stop_edge) begin
                    state_d = ST_EARLY;
                end else if (Tick_ms) begin
                    if (wait_cnt_q == WAIT_ONE) begin
                        state_d     = ST_REACT;
                        react_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_ONE;
                    end
                end
            end
            ST_REACT: begin
                // A response in the same cycle as the last tick still counts.
                if (stop_edge) begin
                    state_d = ST_RESULT;
                end else if (Tick_ms) begin
                    if (react_cnt_q == REACT_LAST) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        react_cnt_d = react_cnt_q + REACT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge registers reset high so inputs already asserted at release are ignored.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            react_cnt_q <= '0;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            react_cnt_q <= react_cnt_d;
            start_q     <= Start;
            stop_q      <= Stop;
            clear_q     <= clear_d;
        end
    end

    assign Counter_clear  = clear_q;
    assign Counter_enable = (state_q == ST_REACT) & Tick_ms;
    assign Led            = (state_q == ST_REACT);
    assign Result_valid   = (state_q == ST_RESULT);
    assign Early          = (state_q == ST_EARLY);
    assign Timeout        = (state_q == ST_TIMEOUT);
    assign State          = state_q;

endmodule

// File: tb/tb_reaction_controller.sv
// Self-checking bench for reaction_controller with short waits and window:
// vector table with scoreboard queue plus hand-written reset-mid-trial sequence.
module tb_reaction_controller;
    import reaction_pkg::*;

    localparam int MIN_W = 3;
    localparam int RB    = 2;
    localparam int TO    = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       tick  = 1'b0;
    logic       counter_clear, counter_enable, led, result_valid, early, timeout;
    logic [2:0] state;

    typedef struct {
        logic       start;
        logic       stop;
        logic       tick;
        logic [2:0] st;
        logic       clr;
        logic       en;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t exp_v;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    reaction_controller #(
        .MIN_WAIT_MS (MIN_W),
        .RAND_BITS   (RB),
        .TIMEOUT_MS  (TO)
    ) dut (
        .Clock          (clk),
        .Resetn         (rst_n),
        .Start          (start),
        .Stop           (stop),
        .Tick_ms        (tick),
        .Counter_clear  (counter_clear),
        .Counter_enable (counter_enable),
        .Led            (led),
        .Result_valid   (result_valid),
        .Early          (early),
        .Timeout        (timeout),
        .State          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference LFSR value seen at the k-th rising edge after reset release.
    function automatic logic [15:0] lfsr_at(input int k);
        logic [15:0] q;
        q = 16'hACE1;
        for (int i = 0; i < k; i++) begin
            q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
        return q;
    endfunction

    function automatic vec_t mk(input logic s, input logic p, input logic t,
                                input logic [2:0] st, input logic clr, input logic en);
        vec_t v;
        v.start = s; v.stop = p; v.tick = t; v.st = st; v.clr = clr; v.en = en;
        return v;
    endfunction

    function automatic void add(input logic s, input logic p, input logic t,
                                input logic [2:0] st, input logic clr, input logic en);
        vecs.push_back(mk(s, p, t, st, clr, en));
    endfunction

    function automatic int wait_len_at(input int k);
        logic [15:0] l;
        l = lfsr_at(k);
        return MIN_W + int'(l[RB-1:0]);
    endfunction

    // Wait ticks then the transition to REACT on the last one.
    function automatic void add_wait(input int n);
        for (int i = 1; i <= n; i++) begin
            add(1'b0, 1'b0, 1'b1, (i == n) ? ST_REACT : ST_WAIT, 1'b0, 1'b0);
        end
    endfunction

    task automatic build();
        int         n;
        int         rem;
        int         rc;
        logic [2:0] cur;
        logic       t;
        logic       en;
        // Trial 1: response after two ticks in REACT.
        add(1'b0, 1'b0, 1'b1, ST_IDLE, 1'b0, 1'b0);
        n = wait_len_at(vecs.size());
        add(1'b1, 1'b0, 1'b1, ST_WAIT, 1'b1, 1'b0);
        add_wait(n);
        add(1'b0, 1'b0, 1'b1, ST_REACT, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, ST_REACT, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, ST_RESULT, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, ST_RESULT, 1'b0, 1'b0);
        // Trial 2: early response during WAIT.
        add(1'b1, 1'b0, 1'b1, ST_WAIT, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, ST_WAIT, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, ST_EARLY, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, ST_EARLY, 1'b0, 1'b0);
        // Trial 3: restart from EARLY, no response, times out.
        n = wait_len_at(vecs.size());
        add(1'b1, 1'b0, 1'b1, ST_WAIT, 1'b1, 1'b0);
        add_wait(n);
        for (int i = 1; i <= TO; i++) begin
            add(1'b0, 1'b0, 1'b1, (i == TO) ? ST_TIMEOUT : ST_REACT, 1'b0, 1'b1);
        end
        add(1'b0, 1'b0, 1'b1, ST_TIMEOUT, 1'b0, 1'b0);
        // Trial 4: response coincides with the final tick, RESULT wins.
        n = wait_len_at(vecs.size());
        add(1'b1, 1'b0, 1'b1, ST_WAIT, 1'b1, 1'b0);
        add_wait(n);
        for (int i = 1; i < TO; i++) begin
            add(1'b0, 1'b0, 1'b1, ST_REACT, 1'b0, 1'b1);
        end
        add(1'b0, 1'b1, 1'b1, ST_RESULT, 1'b0, 1'b1);
        // Trial 5: Start and Stop held high, sparse ticks; one trial, no RESULT.
        n = wait_len_at(vecs.size());
        add(1'b1, 1'b1, 1'b0, ST_WAIT, 1'b1, 1'b0);
        cur = ST_WAIT;
        rem = n;
        rc  = 0;
        for (int k = 0; k < 49; k++) begin
            t  = ((k % 4) == 3);
            en = (cur == ST_REACT) && t;
            if (t) begin
                if (cur == ST_WAIT) begin
                    rem--;
                    if (rem == 0) cur = ST_REACT;
                end else if (cur == ST_REACT) begin
                    rc++;
                    if (rc == TO) cur = ST_TIMEOUT;
                end
            end
            add(1'b1, 1'b1, t, cur, 1'b0, en);
        end
        add(1'b0, 1'b0, 1'b1, ST_TIMEOUT, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, ST_TIMEOUT, 1'b0, 1'b0);
    endtask

    // Called at a falling edge: drive, check the combinational enable, queue the
    // expected post-edge outputs, then advance to the next falling edge.
    task automatic drive(input vec_t v);
        start = v.start;
        stop  = v.stop;
        tick  = v.tick;
        #1;
        check("counter_enable", 16'(counter_enable), 16'(v.en));
        sb.push_back(v);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check("state", 16'(state), 16'(exp_v.st));
            check("counter_clear", 16'(counter_clear), 16'(exp_v.clr));
            check("led", 16'(led), 16'(exp_v.st == ST_REACT));
            check("result_valid", 16'(result_valid), 16'(exp_v.st == ST_RESULT));
            check("early", 16'(early), 16'(exp_v.st == ST_EARLY));
            check("timeout", 16'(timeout), 16'(exp_v.st == ST_TIMEOUT));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 16'(state), 16'(ST_IDLE));
        check({tag, "_clear"}, 16'(counter_clear), 16'd0);
        check({tag, "_enable"}, 16'(counter_enable), 16'd0);
        check({tag, "_led"}, 16'(led), 16'd0);
        check({tag, "_result"}, 16'(result_valid), 16'd0);
        check({tag, "_early"}, 16'(early), 16'd0);
        check({tag, "_timeout"}, 16'(timeout), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        build();
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
        end

        // Reset pulsed mid-REACT, then the LFSR sequence must restart from the seed.
        n = wait_len_at(cyc);
        drive(mk(1'b1, 1'b0, 1'b1, ST_WAIT, 1'b1, 1'b0));
        for (int i = 1; i <= n; i++) begin
            drive(mk(1'b0, 1'b0, 1'b1, (i == n) ? ST_REACT : ST_WAIT, 1'b0, 1'b0));
        end
        drive(mk(1'b0, 1'b0, 1'b1, ST_REACT, 1'b0, 1'b1));
        check("led_before_reset", 16'(led), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("held_reset");
        rst_n = 1'b1;
        cyc   = 0;
        drive(mk(1'b0, 1'b0, 1'b1, ST_IDLE, 1'b0, 1'b0));
        n = wait_len_at(cyc);
        drive(mk(1'b1, 1'b0, 1'b1, ST_WAIT, 1'b1, 1'b0));
        for (int i = 1; i <= n; i++) begin
            drive(mk(1'b0, 1'b0, 1'b1, (i == n) ? ST_REACT : ST_WAIT, 1'b0, 1'b0));
        end
        drive(mk(1'b0, 1'b1, 1'b1, ST_RESULT, 1'b0, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
